ram_port_arbiter: RTL and testbench

//   Shares one single-port synchronous RAM (1 access/cycle, 1-cycle registered read,

---
 rtl/ram_port_arbiter_if.sv | 45 ++++
 rtl/ram_port_arbiter.sv | 85 ++++++++
 tb/tb_ram_port_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// Requester, response and RAM-port signals of the two-requester RAM arbiter.
// slave = arbiter side; master = requesters plus the RAM that feeds rd_data back.
interface ram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  i_r0_valid;
  logic                  o_r0_ready;
  logic                  i_r0_wr_en;
  logic [ADDR_WIDTH-1:0] i_r0_addr;
  logic [DATA_WIDTH-1:0] i_r0_wr_data;
  logic                  o_r0_rsp_valid;
  logic [DATA_WIDTH-1:0] o_r0_rsp_data;

  logic                  i_r1_valid;
  logic                  o_r1_ready;
  logic                  i_r1_wr_en;
  logic [ADDR_WIDTH-1:0] i_r1_addr;
  logic [DATA_WIDTH-1:0] i_r1_wr_data;
  logic                  o_r1_rsp_valid;
  logic [DATA_WIDTH-1:0] o_r1_rsp_data;

  logic [ADDR_WIDTH-1:0] o_ram_addr;
  logic                  o_ram_wr_en;
  logic [DATA_WIDTH-1:0] o_ram_wr_data;
  logic [DATA_WIDTH-1:0] i_ram_rd_data;

  modport slave (
    input  i_r0_valid, i_r0_wr_en, i_r0_addr, i_r0_wr_data,
    output o_r0_ready, o_r0_rsp_valid, o_r0_rsp_data,
    input  i_r1_valid, i_r1_wr_en, i_r1_addr, i_r1_wr_data,
    output o_r1_ready, o_r1_rsp_valid, o_r1_rsp_data,
    output o_ram_addr, o_ram_wr_en, o_ram_wr_data,
    input  i_ram_rd_data
  );

  modport master (
    output i_r0_valid, i_r0_wr_en, i_r0_addr, i_r0_wr_data,
    input  o_r0_ready, o_r0_rsp_valid, o_r0_rsp_data,
    output i_r1_valid, i_r1_wr_en, i_r1_addr, i_r1_wr_data,
    input  o_r1_ready, o_r1_rsp_valid, o_r1_rsp_data,
    input  o_ram_addr, o_ram_wr_en, o_ram_wr_data,
    output i_ram_rd_data
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin share of one single-port sync RAM between two requesters; grant is same-cycle,
// response arrives exactly 1 cycle after handshake; requests backpressured via ready, responses never.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_port_arbiter_if.slave bus
);

  logic [1:0] gnt;
  logic       any_gnt;
  logic       gnt_id;

  logic last_gnt_q, last_gnt_d;
  logic rsp_pend_q, rsp_pend_d;
  logic rsp_id_q,   rsp_id_d;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_wr_en;
  logic [DATA_WIDTH-1:0] ram_wr_data;

  // On contention the requester that did not win last time is granted.
  always_comb begin
    gnt = 2'b00;
    if (bus.i_r0_valid && bus.i_r1_valid) begin
      gnt = last_gnt_q ? 2'b01 : 2'b10;
    end else if (bus.i_r0_valid) begin
      gnt = 2'b01;
    end else if (bus.i_r1_valid) begin
      gnt = 2'b10;
    end
  end

  assign any_gnt = |gnt;
  assign gnt_id  = gnt[1];

  always_comb begin
    ram_addr    = '0;
    ram_wr_en   = 1'b0;
    ram_wr_data = '0;
    if (gnt[0]) begin
      ram_addr    = bus.i_r0_addr;
      ram_wr_en   = bus.i_r0_wr_en;
      ram_wr_data = bus.i_r0_wr_data;
    end else if (gnt[1]) begin
      ram_addr    = bus.i_r1_addr;
      ram_wr_en   = bus.i_r1_wr_en;
      ram_wr_data = bus.i_r1_wr_data;
    end
  end

  always_comb begin
    last_gnt_d = any_gnt ? gnt_id : last_gnt_q;
    rsp_pend_d = any_gnt;
    rsp_id_d   = gnt_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= 1'b1;
      rsp_pend_q <= 1'b0;
      rsp_id_q   <= 1'b0;
    end else begin
      last_gnt_q <= last_gnt_d;
      rsp_pend_q <= rsp_pend_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign bus.o_r0_ready = gnt[0];
  assign bus.o_r1_ready = gnt[1];

  // Gating with rst_n keeps a request held across reset from writing the RAM.
  assign bus.o_ram_addr    = ram_addr;
  assign bus.o_ram_wr_en   = ram_wr_en & rst_n;
  assign bus.o_ram_wr_data = ram_wr_data;

  assign bus.o_r0_rsp_valid = rsp_pend_q & ~rsp_id_q;
  assign bus.o_r1_rsp_valid = rsp_pend_q &  rsp_id_q;
  assign bus.o_r0_rsp_data  = bus.i_ram_rd_data;
  assign bus.o_r1_rsp_data  = bus.i_ram_rd_data;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural read-before-write RAM
// and a constrained-random phase checked against a shadow memory.
module tb_ram_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [DW-1:0] mem    [0:1023];
  logic [DW-1:0] sb_mem [0:1023];

  ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM: registered read of the pre-write contents.
  always @(posedge clk) begin
    bus.i_ram_rd_data <= mem[bus.o_ram_addr];
    if (bus.o_ram_wr_en) mem[bus.o_ram_addr] <= bus.o_ram_wr_data;
  end

  function automatic logic [DW-1:0] init_word(input int a);
    return 32'hA500_0000 ^ a;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_r0_valid = 1'b0; bus.i_r0_wr_en = 1'b0; bus.i_r0_addr = '0; bus.i_r0_wr_data = '0;
    bus.i_r1_valid = 1'b0; bus.i_r1_wr_en = 1'b0; bus.i_r1_addr = '0; bus.i_r1_wr_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #2;
    @(negedge clk);
    checks++; if (bus.o_r0_rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp0 got=%b exp=0", bus.o_r0_rsp_valid); end
    checks++; if (bus.o_r1_rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp1 got=%b exp=0", bus.o_r1_rsp_valid); end
    checks++; if ({bus.o_r0_ready, bus.o_r1_ready} !== 2'b00) begin failures++; $display("FAIL rst_ready got=%b exp=00", {bus.o_r0_ready, bus.o_r1_ready}); end
    checks++; if (bus.o_ram_addr !== 10'h000 || bus.o_ram_wr_en !== 1'b0 || bus.o_ram_wr_data !== 32'h0) begin
      failures++; $display("FAIL rst_ram_idle got=%h/%b/%h exp=000/0/00000000", bus.o_ram_addr, bus.o_ram_wr_en, bus.o_ram_wr_data); end
    // A write held during reset must not reach the RAM.
    bus.i_r0_valid = 1'b1; bus.i_r0_wr_en = 1'b1; bus.i_r0_addr = 10'h005; bus.i_r0_wr_data = 32'h1234_5678;
    #1;
    checks++; if (bus.o_ram_wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_forced got=%b exp=0", bus.o_ram_wr_en); end
    @(posedge clk);
    #1;
    idle_inputs();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++; if (mem[5] !== init_word(5)) begin failures++; $display("FAIL rst_no_write got=%h exp=%h", mem[5], init_word(5)); end
    next_cycle();
  endtask

  task automatic test_single_read();
    bus.i_r0_valid = 1'b1; bus.i_r0_wr_en = 1'b0; bus.i_r0_addr = 10'h010;
    @(negedge clk);
    checks++; if ({bus.o_r0_ready, bus.o_r1_ready} !== 2'b10) begin failures++; $display("FAIL t1_ready got=%b exp=10", {bus.o_r0_ready, bus.o_r1_ready}); end
    checks++; if (bus.o_ram_addr !== 10'h010 || bus.o_ram_wr_en !== 1'b0) begin failures++; $display("FAIL t1_ram got=%h/%b exp=010/0", bus.o_ram_addr, bus.o_ram_wr_en); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.o_r0_rsp_valid !== 1'b1 || bus.o_r0_rsp_data !== 32'hA500_0010) begin
      failures++; $display("FAIL t1_rsp0 got=%b/%h exp=1/a5000010", bus.o_r0_rsp_valid, bus.o_r0_rsp_data); end
    checks++; if (bus.o_r1_rsp_valid !== 1'b0) begin failures++; $display("FAIL t1_rsp1 got=%b exp=0", bus.o_r1_rsp_valid); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.o_r0_rsp_valid !== 1'b0) begin failures++; $display("FAIL t1_rsp0_once got=%b exp=0", bus.o_r0_rsp_valid); end
    next_cycle();
  endtask

  task automatic test_write_then_read();
    bus.i_r1_valid = 1'b1; bus.i_r1_wr_en = 1'b1; bus.i_r1_addr = 10'h3FF; bus.i_r1_wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (bus.o_r1_ready !== 1'b1 || bus.o_ram_wr_en !== 1'b1 || bus.o_ram_addr !== 10'h3FF || bus.o_ram_wr_data !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL t2_wr_issue got=%b/%b/%h/%h exp=1/1/3ff/deadbeef", bus.o_r1_ready, bus.o_ram_wr_en, bus.o_ram_addr, bus.o_ram_wr_data); end
    next_cycle();
    bus.i_r1_wr_en = 1'b0;
    @(negedge clk);
    checks++; if (bus.o_r1_rsp_valid !== 1'b1 || bus.o_r1_rsp_data !== 32'hA500_03FF) begin
      failures++; $display("FAIL t2_wr_rsp_old got=%b/%h exp=1/a50003ff", bus.o_r1_rsp_valid, bus.o_r1_rsp_data); end
    checks++; if (bus.o_r1_ready !== 1'b1 || bus.o_ram_wr_en !== 1'b0) begin failures++; $display("FAIL t2_rd_issue got=%b/%b exp=1/0", bus.o_r1_ready, bus.o_ram_wr_en); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.o_r1_rsp_valid !== 1'b1 || bus.o_r1_rsp_data !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL t2_rd_rsp_new got=%b/%h exp=1/deadbeef", bus.o_r1_rsp_valid, bus.o_r1_rsp_data); end
    checks++; if (bus.o_r0_rsp_valid !== 1'b0) begin failures++; $display("FAIL t2_rsp0 got=%b exp=0", bus.o_r0_rsp_valid); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_rdy;
    bus.i_r0_valid = 1'b1; bus.i_r0_addr = 10'h001;
    bus.i_r1_valid = 1'b1; bus.i_r1_addr = 10'h002;
    for (int k = 0; k < 7; k++) begin
      if (k == 6) idle_inputs();
      @(negedge clk);
      exp_rdy = (k == 6) ? 2'b00 : ((k % 2 == 0) ? 2'b10 : 2'b01);
      checks++; if ({bus.o_r0_ready, bus.o_r1_ready} !== exp_rdy) begin
        failures++; $display("FAIL t3_grant[%0d] got=%b exp=%b", k, {bus.o_r0_ready, bus.o_r1_ready}, exp_rdy); end
      if (k > 0) begin
        if (k % 2 == 1) begin
          checks++; if (bus.o_r0_rsp_valid !== 1'b1 || bus.o_r1_rsp_valid !== 1'b0 || bus.o_r0_rsp_data !== 32'hA500_0001) begin
            failures++; $display("FAIL t3_rsp[%0d] got=%b%b/%h exp=10/a5000001", k, bus.o_r0_rsp_valid, bus.o_r1_rsp_valid, bus.o_r0_rsp_data); end
        end else begin
          checks++; if (bus.o_r0_rsp_valid !== 1'b0 || bus.o_r1_rsp_valid !== 1'b1 || bus.o_r1_rsp_data !== 32'hA500_0002) begin
            failures++; $display("FAIL t3_rsp[%0d] got=%b%b/%h exp=01/a5000002", k, bus.o_r0_rsp_valid, bus.o_r1_rsp_valid, bus.o_r1_rsp_data); end
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_r1_then_r0();
    logic [1:0] exp_rdy;
    bus.i_r1_valid = 1'b1; bus.i_r1_addr = 10'h002;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) begin bus.i_r0_valid = 1'b1; bus.i_r0_addr = 10'h001; end
      @(negedge clk);
      exp_rdy = (k == 3) ? 2'b10 : 2'b01;
      checks++; if ({bus.o_r0_ready, bus.o_r1_ready} !== exp_rdy) begin
        failures++; $display("FAIL t4_grant[%0d] got=%b exp=%b", k, {bus.o_r0_ready, bus.o_r1_ready}, exp_rdy); end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.o_r1_rsp_valid !== 1'b1 || bus.o_r1_rsp_data !== 32'hA500_0002) begin
      failures++; $display("FAIL t4_last_rsp got=%b/%h exp=1/a5000002", bus.o_r1_rsp_valid, bus.o_r1_rsp_data); end
    next_cycle();
  endtask

  task automatic test_reset_inflight();
    // Previous test left R1 as last winner; an R0 grant flips it, reset must restore it.
    bus.i_r0_valid = 1'b1; bus.i_r0_addr = 10'h010;
    @(negedge clk);
    checks++; if (bus.o_r0_ready !== 1'b1) begin failures++; $display("FAIL t5_grant got=%b exp=1", bus.o_r0_ready); end
    next_cycle();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.o_r0_rsp_valid !== 1'b0 || bus.o_r1_rsp_valid !== 1'b0) begin
      failures++; $display("FAIL t5_dropped got=%b%b exp=00", bus.o_r0_rsp_valid, bus.o_r1_rsp_valid); end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.o_r0_rsp_valid !== 1'b0 || bus.o_ram_wr_en !== 1'b0 || bus.o_ram_addr !== 10'h000 || bus.o_ram_wr_data !== 32'h0) begin
      failures++; $display("FAIL t5_idle got=%b/%b/%h/%h exp=0/0/000/00000000", bus.o_r0_rsp_valid, bus.o_ram_wr_en, bus.o_ram_addr, bus.o_ram_wr_data); end
    next_cycle();
    bus.i_r0_valid = 1'b1; bus.i_r0_addr = 10'h001;
    bus.i_r1_valid = 1'b1; bus.i_r1_addr = 10'h002;
    @(negedge clk);
    checks++; if ({bus.o_r0_ready, bus.o_r1_ready} !== 2'b10) begin
      failures++; $display("FAIL t5_first_contention got=%b exp=10", {bus.o_r0_ready, bus.o_r1_ready}); end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_random();
    logic          rq_v [2];
    logic          rq_w [2];
    logic [AW-1:0] rq_a [2];
    logic [DW-1:0] rq_d [2];
    logic          m_last, pend, pid, g, any;
    logic [DW-1:0] pdata;
    logic [AW-1:0] g_a;
    logic          g_w;
    logic [DW-1:0] g_d;
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    m_last = 1'b1; pend = 1'b0; pid = 1'b0; pdata = '0;
    for (int i = 0; i < 2; i++) begin rq_v[i] = 1'b0; rq_w[i] = 1'b0; rq_a[i] = '0; rq_d[i] = '0; end
    for (int cyc = 0; cyc < 3001; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!rq_v[i] && cyc < 3000 && $urandom_range(0, 2) != 0) begin
          rq_v[i] = 1'b1; rq_w[i] = 1'($urandom_range(0, 1));
          rq_a[i] = AW'($urandom_range(0, 7)); rq_d[i] = $urandom;
        end
      end
      bus.i_r0_valid = rq_v[0]; bus.i_r0_wr_en = rq_w[0]; bus.i_r0_addr = rq_a[0]; bus.i_r0_wr_data = rq_d[0];
      bus.i_r1_valid = rq_v[1]; bus.i_r1_wr_en = rq_w[1]; bus.i_r1_addr = rq_a[1]; bus.i_r1_wr_data = rq_d[1];
      @(negedge clk);
      checks++; if (bus.o_r0_rsp_valid !== (pend & ~pid) || bus.o_r1_rsp_valid !== (pend & pid)) begin
        failures++; $display("FAIL rnd_rsp_valid[%0d] got=%b%b exp=%b%b", cyc, bus.o_r0_rsp_valid, bus.o_r1_rsp_valid, pend & ~pid, pend & pid); end
      if (pend) begin
        checks++; if ((pid ? bus.o_r1_rsp_data : bus.o_r0_rsp_data) !== pdata) begin
          failures++; $display("FAIL rnd_rsp_data[%0d] got=%h exp=%h", cyc, pid ? bus.o_r1_rsp_data : bus.o_r0_rsp_data, pdata); end
      end
      any = rq_v[0] | rq_v[1];
      g   = (rq_v[0] && rq_v[1]) ? ~m_last : rq_v[1] & ~rq_v[0];
      checks++; if (bus.o_r0_ready !== (any & ~g) || bus.o_r1_ready !== (any & g)) begin
        failures++; $display("FAIL rnd_grant[%0d] got=%b%b exp=%b%b", cyc, bus.o_r0_ready, bus.o_r1_ready, any & ~g, any & g); end
      if (any) begin
        g_a = rq_a[g]; g_w = rq_w[g]; g_d = rq_d[g];
        checks++; if (bus.o_ram_addr !== g_a || bus.o_ram_wr_en !== g_w || (g_w && bus.o_ram_wr_data !== g_d)) begin
          failures++; $display("FAIL rnd_ram[%0d] got=%h/%b/%h exp=%h/%b/%h", cyc, bus.o_ram_addr, bus.o_ram_wr_en, bus.o_ram_wr_data, g_a, g_w, g_d); end
        pend = 1'b1; pid = g; pdata = sb_mem[g_a];
        if (g_w) sb_mem[g_a] = g_d;
        m_last = g; rq_v[g] = 1'b0;
      end else begin
        pend = 1'b0;
        checks++; if (bus.o_ram_wr_en !== 1'b0) begin failures++; $display("FAIL rnd_idle_wr[%0d] got=%b exp=0", cyc, bus.o_ram_wr_en); end
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    @(negedge clk);
    for (int a = 0; a < 8; a++) begin
      checks++; if (mem[a] !== sb_mem[a]) begin failures++; $display("FAIL rnd_mem[%0d] got=%h exp=%h", a, mem[a], sb_mem[a]); end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int a = 0; a < 1024; a++) begin
      mem[a]    = init_word(a);
      sb_mem[a] = init_word(a);
    end
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_write_then_read();
    test_back_to_back();
    test_r1_then_r0();
    test_reset_inflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
